// File: rtl/shifter_multicycle_pkg.sv
// Shared encodings for the multi-cycle shifter: shift modes and FSM states.
package shifter_multicycle_pkg;

    typedef enum logic [1:0] {
        SHIFT_SLL = 2'b00,
        SHIFT_SRL = 2'b01,
        SHIFT_SRA = 2'b10,
        SHIFT_ROL = 2'b11
    } shift_mode_e;

    typedef enum logic [1:0] {
        S_IDLE  = 2'b00,
        S_SHIFT = 2'b01,
        S_DONE  = 2'b10
    } state_e;

endpackage

// File: rtl/shift_step_unit.sv
// Combinational single step of the shifter: shifts operand by amt (1..STEP) in the given mode.
module shift_step_unit
    import shifter_multicycle_pkg::*;
#(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned STEP  = 1
) (
    input  logic [WIDTH-1:0]       operand,
    input  shift_mode_e            mode,
    input  logic [$clog2(STEP):0]  amt,
    output logic [WIDTH-1:0]       result
);

    // Rotate is the upper half of the doubled word shifted left; no subtraction needed.
    logic [2*WIDTH-1:0] doubled;

    assign doubled = {operand, operand} << amt;

    always_comb begin
        result = operand;
        case (mode)
            SHIFT_SLL: result = operand << amt;
            SHIFT_SRL: result = operand >> amt;
            SHIFT_SRA: result = $unsigned($signed(operand) >>> amt);
            SHIFT_ROL: result = doubled[2*WIDTH-1:WIDTH];
            default:   result = operand;
        endcase
    end

endmodule

// File: rtl/shifter_multicycle.sv
// Multi-cycle shifter: SLL/SRL/SRA/ROL by a runtime amount, at most STEP bits per cycle,
// under a start/ready/valid handshake.
module shifter_multicycle
    import shifter_multicycle_pkg::*;
#(
    parameter int unsigned WIDTH   = 32,
    parameter int unsigned SHAMT_W = $clog2(WIDTH),
    parameter int unsigned STEP    = 1
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               start_i,
    input  logic               flush_i,
    input  logic [1:0]         mode_i,
    input  logic [SHAMT_W-1:0] shamt_i,
    input  logic [WIDTH-1:0]   data_i,
    output logic               ready_o,
    output logic               valid_o,
    output logic [WIDTH-1:0]   data_o
);

    localparam int unsigned KW = $clog2(STEP) + 1;

    state_e             state_q, state_d;
    shift_mode_e        mode_q, mode_d;
    logic [WIDTH-1:0]   work_q, work_d;
    logic [SHAMT_W-1:0] rem_q, rem_d;
    logic [WIDTH-1:0]   result_q, result_d;
    logic               valid_q, valid_d;
    logic [KW-1:0]      k;
    logic [WIDTH-1:0]   stepped;

    // k = min(STEP, remaining); the else branch always fits in KW bits.
    always_comb begin
        if (32'(rem_q) >= STEP) k = KW'(STEP);
        else                    k = KW'(rem_q);
    end

    shift_step_unit #(
        .WIDTH (WIDTH),
        .STEP  (STEP)
    ) u_step (
        .operand (work_q),
        .mode    (mode_q),
        .amt     (k),
        .result  (stepped)
    );

    always_comb begin
        state_d  = state_q;
        mode_d   = mode_q;
        work_d   = work_q;
        rem_d    = rem_q;
        result_d = result_q;
        valid_d  = 1'b0;
        case (state_q)
            S_IDLE: begin
                // A flush in IDLE swallows a simultaneous start.
                if (start_i && !flush_i) begin
                    work_d  = data_i;
                    rem_d   = shamt_i;
                    mode_d  = shift_mode_e'(mode_i);
                    state_d = (shamt_i != '0) ? S_SHIFT : S_DONE;
                end
            end
            S_SHIFT: begin
                if (flush_i) begin
                    state_d = S_IDLE;
                end else begin
                    work_d = stepped;
                    rem_d  = rem_q - SHAMT_W'(k);
                    if (rem_d == '0) state_d = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
                if (!flush_i) begin
                    result_d = work_q;
                    valid_d  = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q  <= S_IDLE;
            mode_q   <= SHIFT_SLL;
            work_q   <= '0;
            rem_q    <= '0;
            result_q <= '0;
            valid_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            mode_q   <= mode_d;
            work_q   <= work_d;
            rem_q    <= rem_d;
            result_q <= result_d;
            valid_q  <= valid_d;
        end
    end

    assign ready_o = (state_q == S_IDLE);
    assign valid_o = valid_q;
    assign data_o  = result_q;

endmodule

// File: tb/tb_shifter_multicycle.sv
// Scoreboard bench: three shifters (STEP 1/4/8) share operands; each has its own start and queue.
module tb_shifter_multicycle;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [2:0]  start;
    logic        flush;
    logic [1:0]  mode;
    logic [4:0]  shamt;
    logic [31:0] din;
    logic [2:0]  ready;
    logic [2:0]  valid;
    logic [31:0] dout [3];

    always #5 clk = ~clk;

    shifter_multicycle #(.WIDTH(32), .SHAMT_W(5), .STEP(1)) u_dut0 (
        .clk_i(clk), .rst_i(rst_n), .start_i(start[0]), .flush_i(flush), .mode_i(mode),
        .shamt_i(shamt), .data_i(din), .ready_o(ready[0]), .valid_o(valid[0]), .data_o(dout[0])
    );
    shifter_multicycle #(.WIDTH(32), .SHAMT_W(5), .STEP(4)) u_dut1 (
        .clk_i(clk), .rst_i(rst_n), .start_i(start[1]), .flush_i(flush), .mode_i(mode),
        .shamt_i(shamt), .data_i(din), .ready_o(ready[1]), .valid_o(valid[1]), .data_o(dout[1])
    );
    shifter_multicycle #(.WIDTH(32), .SHAMT_W(5), .STEP(8)) u_dut2 (
        .clk_i(clk), .rst_i(rst_n), .start_i(start[2]), .flush_i(flush), .mode_i(mode),
        .shamt_i(shamt), .data_i(din), .ready_o(ready[2]), .valid_o(valid[2]), .data_o(dout[2])
    );

    typedef struct {
        logic [31:0] data;
        int          cyc;
    } exp_t;

    exp_t sb0[$];
    exp_t sb1[$];
    exp_t sb2[$];
    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic int sb_size(input int i);
        case (i)
            0:       return sb0.size();
            1:       return sb1.size();
            default: return sb2.size();
        endcase
    endfunction

    task automatic sb_push(input int i, input exp_t e);
        case (i)
            0:       sb0.push_back(e);
            1:       sb1.push_back(e);
            default: sb2.push_back(e);
        endcase
    endtask

    task automatic sb_pop(input int i, output exp_t e, output bit ok);
        ok = (sb_size(i) != 0);
        e.data = '0;
        e.cyc  = 0;
        if (ok) begin
            case (i)
                0:       e = sb0.pop_front();
                1:       e = sb1.pop_front();
                default: e = sb2.pop_front();
            endcase
        end
    endtask

    task automatic sb_clear(input int i);
        case (i)
            0:       sb0.delete();
            1:       sb1.delete();
            default: sb2.delete();
        endcase
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: every valid pulse must match the oldest expectation, in data and in cycle.
    always @(negedge clk) begin
        exp_t e;
        bit   ok;
        if (rst_n) begin
            for (int i = 0; i < 3; i++) begin
                if (valid[i]) begin
                    sb_pop(i, e, ok);
                    if (!ok) begin
                        total++;
                        bad++;
                        $display("FAIL dut%0d unexpected valid: got data %h expected no pulse",
                                 i, dout[i]);
                    end else begin
                        check($sformatf("dut%0d data", i), dout[i], e.data);
                        check($sformatf("dut%0d valid cycle", i), 32'(cyc), 32'(e.cyc));
                    end
                end
            end
        end
    end

    // Issue one request to dut i once it is ready; expectation pushed only if push=1.
    task automatic issue(input int i, input logic [1:0] m, input logic [4:0] sa,
                         input logic [31:0] d, input logic [31:0] expv, input int step,
                         input bit push);
        int   n = 0;
        exp_t e;
        @(negedge clk);
        while (!ready[i] && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!ready[i]) begin
            total++;
            bad++;
            $display("FAIL dut%0d ready timeout: got 0 expected 1", i);
        end
        mode     = m;
        shamt    = sa;
        din      = d;
        start[i] = 1'b1;
        e.data   = expv;
        e.cyc    = cyc + 1 + (int'(sa) + step - 1) / step + 1;
        if (push) sb_push(i, e);
        @(negedge clk);
        start[i] = 1'b0;
    endtask

    task automatic wait_done(input int i);
        int n = 0;
        while (sb_size(i) != 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (sb_size(i) != 0) begin
            total++;
            bad++;
            $display("FAIL dut%0d completion timeout: got %0d pending expected 0", i, sb_size(i));
            sb_clear(i);
        end
        @(negedge clk);
        check($sformatf("dut%0d ready after done", i), 32'(ready[i]), 32'd1);
    endtask

    initial begin
        rst_n = 1'b0;
        start = '0;
        flush = 1'b0;
        mode  = 2'b00;
        shamt = '0;
        din   = '0;
        repeat (2) @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            check($sformatf("dut%0d reset ready", i), 32'(ready[i]), 32'd1);
            check($sformatf("dut%0d reset valid", i), 32'(valid[i]), 32'd0);
            check($sformatf("dut%0d reset data", i), dout[i], 32'h0);
        end
        rst_n = 1'b1;

        issue(0, 2'b00, 5'd2, 32'h0000_0001, 32'h0000_0004, 1, 1'b1);
        wait_done(0);
        issue(1, 2'b10, 5'd7, 32'h8000_00F0, 32'hFF00_0001, 4, 1'b1);
        wait_done(1);
        issue(2, 2'b11, 5'd31, 32'h8000_0001, 32'hC000_0000, 8, 1'b1);
        wait_done(2);
        issue(2, 2'b01, 5'd0, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 8, 1'b1);
        wait_done(2);
        issue(1, 2'b01, 5'd4, 32'h8000_0010, 32'h0800_0001, 4, 1'b1);
        wait_done(1);
        issue(2, 2'b00, 5'd20, 32'h0000_0ABC, 32'hABC0_0000, 8, 1'b1);
        wait_done(2);

        // start held high with other operands while busy must be ignored.
        issue(0, 2'b01, 5'd4, 32'hF000_0000, 32'h0F00_0000, 1, 1'b1);
        mode     = 2'b00;
        shamt    = 5'd1;
        din      = 32'h1234_5678;
        start[0] = 1'b1;
        repeat (3) @(negedge clk);
        start[0] = 1'b0;
        wait_done(0);
        repeat (4) @(negedge clk);

        // flush in IDLE suppresses a simultaneous start.
        @(negedge clk);
        mode     = 2'b00;
        shamt    = 5'd3;
        din      = 32'h0000_0001;
        flush    = 1'b1;
        start[0] = 1'b1;
        @(negedge clk);
        flush    = 1'b0;
        start[0] = 1'b0;
        check("dut0 flush idle ready", 32'(ready[0]), 32'd1);

        // flush in the second SHIFT cycle: no result, old data kept.
        issue(1, 2'b00, 5'd12, 32'h0000_0001, 32'h0000_1000, 4, 1'b0);
        @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        check("dut1 ready after flush", 32'(ready[1]), 32'd1);
        check("dut1 data after flush", dout[1], 32'h0800_0001);
        repeat (6) @(negedge clk);
        check("dut1 data held", dout[1], 32'h0800_0001);

        // asynchronous reset mid-SHIFT, then a fresh operation.
        issue(0, 2'b00, 5'd31, 32'h0000_0001, 32'h8000_0000, 1, 1'b0);
        repeat (5) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("dut0 async reset ready", 32'(ready[0]), 32'd1);
        check("dut0 async reset valid", 32'(valid[0]), 32'd0);
        check("dut0 async reset data", dout[0], 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        issue(0, 2'b00, 5'd31, 32'h0000_0001, 32'h8000_0000, 1, 1'b1);
        wait_done(0);
        repeat (3) @(negedge clk);
        check("dut0 data held after done", dout[0], 32'h8000_0000);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
